timer_core: RTL and testbench

Functional counterpart of the CLINT-style timer register block. It holds the free-running 64-bit `mtime` counter, advanced by a programmable prescaler, and feeds `mtime` to the register block for readback. It consumes `mtimecmp` and `msip` from the register block and produces the registered machine timer interrupt (`mtip`) and software interrupt (`msip_irq`) toward the core's interrupt logic.

---
 rtl/timer_core_pkg.sv | 6 +
 rtl/timer_prescaler.sv | 24 ++
 rtl/timer_core.sv | 59 +++++
 tb/tb_timer_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_core_pkg.sv
// timer_core_pkg: shared widths and default tick divider for the machine timer
package timer_core_pkg;
  localparam int XLEN = 32;
  localparam int MTIME_W = 64;
  localparam int TIMER_TICK_DIV_DEFAULT = 100;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by TICK_DIV into a one-cycle tick (ports clk, rst, en, clr in; tick out)
module timer_prescaler
  import timer_core_pkg::*;
#(
  parameter int TICK_DIV = TIMER_TICK_DIV_DEFAULT,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICK_DIV - 1);
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  assign tick = en && !clr && pcnt_q == LAST;
  always_comb begin
    pcnt_d = clr ? '0 : !en ? pcnt_q : tick ? '0 : pcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/timer_core.sv
// timer_core: 64-bit mtime counter with loads, hi-word snapshot, mtip compare and msip_irq flops
module timer_core
  import timer_core_pkg::*;
#(
  parameter int TICK_DIV = TIMER_TICK_DIV_DEFAULT,
  parameter int PRESCALE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [MTIME_W-1:0] mtimecmp,
  input  logic [XLEN-1:0]    msip,
  input  logic               mtime_we_lo,
  input  logic               mtime_we_hi,
  input  logic [XLEN-1:0]    mtime_wdata,
  input  logic               snap_lo,
  output logic [MTIME_W-1:0] mtime,
  output logic [XLEN-1:0]    mtime_hi_snap,
  output logic               mtip,
  output logic               msip_irq
);
  logic [MTIME_W-1:0] mtime_q, mtime_d;
  logic [XLEN-1:0] snap_q, snap_d;
  logic mtip_q, mtip_d, irq_q, irq_d, tick, load;
  logic msip_unused;
  assign msip_unused = |msip[XLEN-1:1];
  assign load = mtime_we_lo | mtime_we_hi;
  timer_prescaler #(.TICK_DIV(TICK_DIV), .PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );
  always_comb begin
    mtime_d = load ? {mtime_we_hi ? mtime_wdata : mtime_q[63:32], mtime_we_lo ? mtime_wdata : mtime_q[31:0]}
                   : tick ? mtime_q + 1'b1 : mtime_q;
    mtip_d = mtime_q >= mtimecmp;
    irq_d = msip[0];
    snap_d = snap_lo ? mtime_q[63:32] : snap_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      snap_q <= '0;
      mtip_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      snap_q <= snap_d;
      mtip_q <= mtip_d;
      irq_q <= irq_d;
    end
  end
  assign mtime = mtime_q;
  assign mtime_hi_snap = snap_q;
  assign mtip = mtip_q;
  assign msip_irq = irq_q;
endmodule

// File: tb/tb_timer_core.sv
// tb_timer_core: scoreboard bench for timer_core with TICK_DIV=4 (a_*) and TICK_DIV=1 (b_*)
module tb_timer_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_en, a_we_lo, a_we_hi, a_snap_lo, a_mtip, a_msip_irq;
  logic [63:0] a_cmp, a_mtime;
  logic [31:0] a_msip, a_wdata, a_snap;
  logic b_rst, b_en, b_we_lo, b_we_hi, b_snap_lo, b_mtip, b_msip_irq;
  logic [63:0] b_cmp, b_mtime;
  logic [31:0] b_msip, b_wdata, b_snap;
  typedef struct {
    string name;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  timer_core #(.TICK_DIV(4), .PRESCALE_W(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mtimecmp(a_cmp), .msip(a_msip),
    .mtime_we_lo(a_we_lo), .mtime_we_hi(a_we_hi), .mtime_wdata(a_wdata), .snap_lo(a_snap_lo),
    .mtime(a_mtime), .mtime_hi_snap(a_snap), .mtip(a_mtip), .msip_irq(a_msip_irq)
  );
  timer_core #(.TICK_DIV(1), .PRESCALE_W(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mtimecmp(b_cmp), .msip(b_msip),
    .mtime_we_lo(b_we_lo), .mtime_we_hi(b_we_hi), .mtime_wdata(b_wdata), .snap_lo(b_snap_lo),
    .mtime(b_mtime), .mtime_hi_snap(b_snap), .mtip(b_mtip), .msip_irq(b_msip_irq)
  );
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t e;
    {a_rst, a_en, a_we_lo, a_we_hi, a_snap_lo} = 5'b10000;
    {b_rst, b_en, b_we_lo, b_we_hi, b_snap_lo} = 5'b10000;
    a_cmp = '0; a_msip = '0; a_wdata = '0;
    b_cmp = '0; b_msip = '0; b_wdata = '0;
    sb.push_back('{"rst_mtime", 64'h0});
    sb.push_back('{"rst_mtip", 64'h0});
    sb.push_back('{"rst_irq", 64'h0});
    sb.push_back('{"rst_snap", 64'h0});
    sb.push_back('{"rst_b_mtime", 64'h0});
    step(2);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtip, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_msip_irq) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_msip_irq, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_snap) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_snap, e.val); end
    e = sb.pop_front(); checks++;
    if (b_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_mtime, e.val); end
  endtask
  task automatic test_count();
    exp_t e;
    a_rst = 1'b0; a_en = 1'b1; a_cmp = 64'd3;
    for (int k = 1; k <= 16; k++) begin
      sb.push_back('{$sformatf("cnt_mtime_e%0d", k), 64'(k / 4)});
      sb.push_back('{$sformatf("cnt_mtip_e%0d", k), 64'(k >= 13)});
      step(1);
      e = sb.pop_front(); checks++;
      if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
      e = sb.pop_front(); checks++;
      if (64'(a_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtip, e.val); end
    end
  endtask
  task automatic test_load_on_tick();
    exp_t e;
    step(3);
    a_we_lo = 1'b1; a_we_hi = 1'b1; a_wdata = 32'h10;
    sb.push_back('{"ld_both", 64'h10_0000_0010});
    step(1);
    a_we_lo = 1'b0; a_we_hi = 1'b0;
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    sb.push_back('{"ld_hold3", 64'h10_0000_0010});
    step(3);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    sb.push_back('{"ld_next_inc", 64'h10_0000_0011});
    step(1);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    a_we_lo = 1'b1; a_wdata = 32'h5;
    sb.push_back('{"ld_lo_only", 64'h10_0000_0005});
    step(1);
    a_we_lo = 1'b0;
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
  endtask
  task automatic test_snapshot();
    exp_t e;
    a_we_hi = 1'b1; a_wdata = 32'h1;
    step(1);
    a_we_hi = 1'b0; a_we_lo = 1'b1; a_wdata = 32'hFFFF_FFFF;
    step(1);
    a_we_lo = 1'b0;
    step(3);
    a_snap_lo = 1'b1;
    sb.push_back('{"snap_mtime", 64'h2_0000_0000});
    sb.push_back('{"snap_hi", 64'h1});
    step(1);
    a_snap_lo = 1'b0;
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_snap) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_snap, e.val); end
  endtask
  task automatic test_enable_hold();
    exp_t e;
    step(2);
    a_en = 1'b0;
    sb.push_back('{"en_frozen", 64'h2_0000_0000});
    step(10);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    a_en = 1'b1;
    sb.push_back('{"en_resume1", 64'h2_0000_0000});
    step(1);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    sb.push_back('{"en_resume2", 64'h2_0000_0001});
    step(1);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    a_en = 1'b0; a_we_lo = 1'b1; a_wdata = 32'h7;
    sb.push_back('{"ld_en_off", 64'h2_0000_0007});
    step(1);
    a_we_lo = 1'b0;
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    a_en = 1'b1;
    sb.push_back('{"ld_en_hold3", 64'h2_0000_0007});
    step(3);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    sb.push_back('{"ld_en_inc", 64'h2_0000_0008});
    step(1);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
  endtask
  task automatic test_msip();
    exp_t e;
    a_msip = 32'h1;
    sb.push_back('{"msip_pre_edge", 64'h0});
    sb.push_back('{"msip_set", 64'h1});
    e = sb.pop_front(); checks++;
    if (64'(a_msip_irq) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_msip_irq, e.val); end
    step(1);
    e = sb.pop_front(); checks++;
    if (64'(a_msip_irq) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_msip_irq, e.val); end
    a_msip = 32'h2;
    sb.push_back('{"msip_bit1_only", 64'h0});
    step(1);
    e = sb.pop_front(); checks++;
    if (64'(a_msip_irq) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_msip_irq, e.val); end
    a_msip = 32'h0;
  endtask
  task automatic test_compare();
    exp_t e;
    a_cmp = '1;
    sb.push_back('{"cmp_raised", 64'h0});
    step(1);
    e = sb.pop_front(); checks++;
    if (64'(a_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtip, e.val); end
    a_cmp = 64'h2_0000_0008;
    sb.push_back('{"cmp_equal", 64'h1});
    step(1);
    e = sb.pop_front(); checks++;
    if (64'(a_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtip, e.val); end
  endtask
  task automatic test_reset_mid();
    exp_t e;
    a_msip = 32'h1; a_snap_lo = 1'b1; a_cmp = '0;
    step(1);
    a_snap_lo = 1'b0;
    a_rst = 1'b1; a_we_lo = 1'b1; a_wdata = 32'h9;
    sb.push_back('{"rmid_mtime", 64'h0});
    sb.push_back('{"rmid_mtip", 64'h0});
    sb.push_back('{"rmid_irq", 64'h0});
    sb.push_back('{"rmid_snap", 64'h0});
    step(1);
    a_rst = 1'b0; a_we_lo = 1'b0; a_msip = 32'h0;
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtip, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_msip_irq) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_msip_irq, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(a_snap) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_snap, e.val); end
    sb.push_back('{"rmid_hold3", 64'h0});
    step(3);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
    sb.push_back('{"rmid_first_inc", 64'h1});
    step(1);
    e = sb.pop_front(); checks++;
    if (a_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, a_mtime, e.val); end
  endtask
  task automatic test_wrap();
    exp_t e;
    b_rst = 1'b0; b_en = 1'b1; b_cmp = '1;
    b_we_lo = 1'b1; b_we_hi = 1'b1; b_wdata = 32'hFFFF_FFFF;
    sb.push_back('{"wrap_load", 64'hFFFF_FFFF_FFFF_FFFF});
    sb.push_back('{"wrap_mtip0", 64'h0});
    step(1);
    b_we_lo = 1'b0; b_we_hi = 1'b0;
    e = sb.pop_front(); checks++;
    if (b_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_mtime, e.val); end
    e = sb.pop_front(); checks++;
    if (64'(b_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_mtip, e.val); end
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{$sformatf("wrap_mtime_%0d", k), 64'(k)});
      sb.push_back('{$sformatf("wrap_mtip_%0d", k), 64'(k == 0)});
      step(1);
      e = sb.pop_front(); checks++;
      if (b_mtime !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_mtime, e.val); end
      e = sb.pop_front(); checks++;
      if (64'(b_mtip) !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, b_mtip, e.val); end
    end
  endtask
  initial begin
    test_reset();
    test_count();
    test_load_on_tick();
    test_snapshot();
    test_enable_hold();
    test_msip();
    test_compare();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
